// File: rtl/alarm_pkg.sv
// Shared types and helpers for the alarm ringer block.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] hourdec;
        logic [3:0] hourone;
        logic [3:0] mindec;
        logic [3:0] minone;
    } bcd_time_t;

    // Raw digit-by-digit equality; digits are not checked for BCD validity.
    function automatic logic bcd_time_eq(input bcd_time_t a, input bcd_time_t b);
        return (a.hourdec == b.hourdec) && (a.hourone == b.hourone) &&
               (a.mindec  == b.mindec)  && (a.minone  == b.minone);
    endfunction

endpackage

// File: rtl/alarm_ringer_if.sv
// Time/alarm inputs, user controls and speaker/LED outputs of the alarm ringer.
interface alarm_ringer_if;

    logic       sec_tick;
    logic [3:0] hourdec_now;
    logic [3:0] hourone_now;
    logic [3:0] mindec_now;
    logic [3:0] minone_now;
    logic [3:0] hourdec_alarm;
    logic [3:0] hourone_alarm;
    logic [3:0] mindec_alarm;
    logic [3:0] minone_alarm;
    logic       alarm_en;
    logic       stop;
    logic       snooze;
    logic       sound;
    logic       ringing;
    logic       snoozed;

    // Watch side: drives time, alarm setting and buttons; reads status.
    modport master (
        output sec_tick,
        output hourdec_now, hourone_now, mindec_now, minone_now,
        output hourdec_alarm, hourone_alarm, mindec_alarm, minone_alarm,
        output alarm_en, stop, snooze,
        input  sound, ringing, snoozed
    );

    // Ringer side.
    modport slave (
        input  sec_tick,
        input  hourdec_now, hourone_now, mindec_now, minone_now,
        input  hourdec_alarm, hourone_alarm, mindec_alarm, minone_alarm,
        input  alarm_en, stop, snooze,
        output sound, ringing, snoozed
    );

endinterface

// File: rtl/alarm_ringer_tone_gen.sv
// Square-wave tone divider: toggles tone every HALF clocks while enabled,
// held cleared (divider and tone) whenever disabled.
module tone_gen #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TONE_HZ = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tone
);

    localparam int HALF = CLK_HZ / (2 * TONE_HZ);
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tone_q, tone_d;

    // Next divider count and tone level; wrap toggles the tone.
    always_comb begin
        cnt_d  = cnt_q;
        tone_d = tone_q;
        if (!en) begin
            cnt_d  = '0;
            tone_d = 1'b0;
        end else if (cnt_q == LAST) begin
            cnt_d  = '0;
            tone_d = ~tone_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Divider and tone registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tone_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tone_q <= tone_d;
        end
    end

    assign tone = tone_q;

endmodule

// File: rtl/alarm_ringer.sv
// Alarm ringer: detects arrival at the alarm time and runs the
// ring / snooze / stop state machine driving a 1 s on / 1 s off tone.
module alarm_ringer
    import alarm_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int TONE_HZ    = 1000,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300
) (
    input  logic           clk,
    input  logic           rst,
    alarm_ringer_if.slave  bus
);

    localparam int RCW = $clog2(RING_SEC + 1);
    localparam int SCW = $clog2(SNOOZE_SEC + 1);

    bcd_time_t now_time, alarm_time;
    logic      match, trigger, tone, tone_en;

    state_t         state_q, state_d;
    logic [RCW-1:0] ring_cnt_q, ring_cnt_d;
    logic [SCW-1:0] snooze_cnt_q, snooze_cnt_d;
    logic           beep_phase_q, beep_phase_d;
    logic           match_prev_q, match_prev_d;
    logic           ringing_q, ringing_d;
    logic           snoozed_q, snoozed_d;
    logic           sound_q, sound_d;

    assign now_time   = {bus.hourdec_now, bus.hourone_now, bus.mindec_now, bus.minone_now};
    assign alarm_time = {bus.hourdec_alarm, bus.hourone_alarm, bus.mindec_alarm, bus.minone_alarm};

    // Only the arrival at the alarm time rings; holding the time there does not retrigger.
    assign match   = bcd_time_eq(now_time, alarm_time);
    assign trigger = match & ~match_prev_q & bus.alarm_en;

    // The divider only runs while ringing, so every entry to RINGING starts it from zero.
    assign tone_en = (state_q == RINGING);

    tone_gen #(
        .CLK_HZ  (CLK_HZ),
        .TONE_HZ (TONE_HZ)
    ) u_tone_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (tone_en),
        .tone (tone)
    );

    // Next-state, counter, cadence and output decode, highest priority first.
    always_comb begin
        state_d      = state_q;
        ring_cnt_d   = ring_cnt_q;
        snooze_cnt_d = snooze_cnt_q;
        beep_phase_d = beep_phase_q;
        match_prev_d = match;

        if (!bus.alarm_en) begin
            state_d = IDLE;
        end else if (bus.stop && (state_q != IDLE)) begin
            state_d = IDLE;
        end else if (bus.snooze && (state_q == RINGING)) begin
            state_d      = SNOOZE;
            snooze_cnt_d = SCW'(SNOOZE_SEC);
        end else begin
            case (state_q)
                IDLE: begin
                    if (trigger) begin
                        state_d      = RINGING;
                        ring_cnt_d   = RCW'(RING_SEC);
                        beep_phase_d = 1'b1;
                    end
                end
                RINGING: begin
                    if (bus.sec_tick) begin
                        if (ring_cnt_q == RCW'(1)) begin
                            state_d = IDLE;
                        end else begin
                            ring_cnt_d   = ring_cnt_q - RCW'(1);
                            beep_phase_d = ~beep_phase_q;
                        end
                    end
                end
                SNOOZE: begin
                    if (bus.sec_tick) begin
                        if (snooze_cnt_q == SCW'(1)) begin
                            state_d      = RINGING;
                            ring_cnt_d   = RCW'(RING_SEC);
                            beep_phase_d = 1'b1;
                        end else begin
                            snooze_cnt_d = snooze_cnt_q - SCW'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        ringing_d = (state_d == RINGING);
        snoozed_d = (state_d == SNOOZE);
        sound_d   = tone & beep_phase_d & (state_d == RINGING);
    end

    // State and registered outputs; match history starts high so reset cannot trigger.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ring_cnt_q   <= '0;
            snooze_cnt_q <= '0;
            beep_phase_q <= 1'b0;
            match_prev_q <= 1'b1;
            ringing_q    <= 1'b0;
            snoozed_q    <= 1'b0;
            sound_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ring_cnt_q   <= ring_cnt_d;
            snooze_cnt_q <= snooze_cnt_d;
            beep_phase_q <= beep_phase_d;
            match_prev_q <= match_prev_d;
            ringing_q    <= ringing_d;
            snoozed_q    <= snoozed_d;
            sound_q      <= sound_d;
        end
    end

    assign bus.sound   = sound_q;
    assign bus.ringing = ringing_q;
    assign bus.snoozed = snoozed_q;

endmodule

// File: tb/tb_alarm_ringer.sv
// Directed bench for alarm_ringer: per-cycle vector table plus cadence,
// snooze-return and reset sequences.
module tb_alarm_ringer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    alarm_ringer_if bus ();

    alarm_ringer #(
        .CLK_HZ     (1000),
        .TONE_HZ    (100),
        .RING_SEC   (3),
        .SNOOZE_SEC (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] now;
        logic [15:0] alarm;
        logic        en;
        logic        stp;
        logic        snz;
        logic        tick;
        logic        exp_ring;
        logic        exp_snz;
        logic        exp_sound;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_time(input logic [15:0] t);
        {bus.hourdec_now, bus.hourone_now, bus.mindec_now, bus.minone_now} = t;
    endtask

    task automatic set_alarm(input logic [15:0] t);
        {bus.hourdec_alarm, bus.hourone_alarm, bus.mindec_alarm, bus.minone_alarm} = t;
    endtask

    task automatic pulse_tick();
        bus.sec_tick = 1'b1;
        step();
        bus.sec_tick = 1'b0;
    endtask

    // Move to 07:31 then 07:30 so the alarm fires; ringing is checked after the trigger edge.
    task automatic arrive(input string name);
        set_time(16'h0731);
        step();
        set_time(16'h0730);
        step();
        check({name, " ringing on arrival"}, bus.ringing, 1'b1);
    endtask

    initial begin
        bit saw_high;

        // now, alarm, en, stop, snooze, tick, ringing, snoozed, sound
        vecs.push_back('{16'h0729, 16'h0730, 1, 0, 0, 0, 0, 0, 0}); // 0 approach
        vecs.push_back('{16'h0730, 16'h0730, 1, 0, 0, 0, 1, 0, 0}); // 1 arrival rings
        vecs.push_back('{16'h0730, 16'h0730, 1, 0, 0, 0, 1, 0, 0}); // 2 hold
        vecs.push_back('{16'h0730, 16'h0730, 1, 0, 1, 0, 0, 1, 0}); // 3 snooze
        vecs.push_back('{16'h0730, 16'h0730, 1, 0, 0, 0, 0, 1, 0}); // 4
        vecs.push_back('{16'h0730, 16'h0730, 1, 0, 0, 1, 0, 1, 0}); // 5 snooze 2->1
        vecs.push_back('{16'h0730, 16'h0730, 1, 0, 0, 1, 1, 0, 0}); // 6 back to ringing
        vecs.push_back('{16'h0730, 16'h0730, 1, 1, 1, 0, 0, 0, 0}); // 7 stop beats snooze
        vecs.push_back('{16'h0730, 16'h0730, 1, 0, 0, 0, 0, 0, 0}); // 8 held, no retrigger
        vecs.push_back('{16'h0731, 16'h0730, 1, 0, 0, 0, 0, 0, 0}); // 9 leave
        vecs.push_back('{16'h0730, 16'h0730, 1, 0, 0, 0, 1, 0, 0}); // 10 re-arrive
        vecs.push_back('{16'h0730, 16'h0730, 1, 0, 1, 0, 0, 1, 0}); // 11 snooze
        vecs.push_back('{16'h0730, 16'h0730, 0, 0, 0, 0, 0, 0, 0}); // 12 disarm in SNOOZE
        vecs.push_back('{16'h0730, 16'h0730, 1, 0, 0, 0, 0, 0, 0}); // 13 rearm, held time
        vecs.push_back('{16'h0729, 16'h0730, 1, 0, 0, 0, 0, 0, 0}); // 14
        vecs.push_back('{16'h0730, 16'h0730, 1, 0, 0, 0, 1, 0, 0}); // 15 rings
        vecs.push_back('{16'h0730, 16'h0730, 1, 1, 0, 0, 0, 0, 0}); // 16 stop
        vecs.push_back('{16'h0731, 16'h0730, 1, 0, 0, 0, 0, 0, 0}); // 17
        vecs.push_back('{16'h0730, 16'h0730, 1, 0, 0, 0, 1, 0, 0}); // 18 rings, cnt=3
        vecs.push_back('{16'h0730, 16'h0730, 1, 0, 0, 1, 1, 0, 0}); // 19 cnt 2
        vecs.push_back('{16'h0730, 16'h0730, 1, 0, 0, 1, 1, 0, 0}); // 20 cnt 1
        vecs.push_back('{16'h0730, 16'h0730, 1, 0, 1, 1, 0, 1, 0}); // 21 snooze beats last tick
        vecs.push_back('{16'h0730, 16'h0730, 1, 1, 0, 0, 0, 0, 0}); // 22 stop in SNOOZE
        vecs.push_back('{16'h1359, 16'h2359, 1, 0, 0, 0, 0, 0, 0}); // 23 hour tens differ
        vecs.push_back('{16'h2259, 16'h2359, 1, 0, 0, 0, 0, 0, 0}); // 24 hour ones differ
        vecs.push_back('{16'h2349, 16'h2359, 1, 0, 0, 0, 0, 0, 0}); // 25 minute tens differ
        vecs.push_back('{16'h2358, 16'h2359, 1, 0, 0, 0, 0, 0, 0}); // 26 minute ones differ
        vecs.push_back('{16'h2358, 16'h2359, 0, 0, 0, 0, 0, 0, 0}); // 27 disarmed
        vecs.push_back('{16'h2359, 16'h2359, 0, 0, 0, 0, 0, 0, 0}); // 28 arrival while disarmed
        vecs.push_back('{16'h2359, 16'h2359, 1, 0, 0, 0, 0, 0, 0}); // 29 arm later, same minute
        vecs.push_back('{16'h2359, 16'h2359, 1, 0, 1, 0, 0, 0, 0}); // 30 snooze in IDLE ignored
        vecs.push_back('{16'h2358, 16'h2359, 1, 0, 0, 0, 0, 0, 0}); // 31
        vecs.push_back('{16'h2359, 16'h2359, 1, 0, 0, 0, 1, 0, 0}); // 32 rings at 23:59
        vecs.push_back('{16'h2359, 16'h2359, 1, 1, 0, 0, 0, 0, 0}); // 33 stop

        bus.sec_tick = 1'b0;
        bus.alarm_en = 1'b1;
        bus.stop     = 1'b0;
        bus.snooze   = 1'b0;
        set_time(16'h0729);
        set_alarm(16'h0730);

        rst = 1'b1;
        repeat (3) step();
        check("reset ringing", bus.ringing, 1'b0);
        check("reset snoozed", bus.snoozed, 1'b0);
        check("reset sound", bus.sound, 1'b0);
        rst = 1'b0;

        // Per-cycle vector table.
        foreach (vecs[i]) begin
            set_time(vecs[i].now);
            set_alarm(vecs[i].alarm);
            bus.alarm_en = vecs[i].en;
            bus.stop     = vecs[i].stp;
            bus.snooze   = vecs[i].snz;
            bus.sec_tick = vecs[i].tick;
            step();
            bus.stop     = 1'b0;
            bus.snooze   = 1'b0;
            bus.sec_tick = 1'b0;
            $display("row %0d now=%h alarm=%h en=%b stop=%b snz=%b tick=%b -> ringing=%b snoozed=%b sound=%b",
                     i, vecs[i].now, vecs[i].alarm, vecs[i].en, vecs[i].stp, vecs[i].snz,
                     vecs[i].tick, bus.ringing, bus.snoozed, bus.sound);
            check($sformatf("row%0d ringing", i), bus.ringing, vecs[i].exp_ring);
            check($sformatf("row%0d snoozed", i), bus.snoozed, vecs[i].exp_snz);
            check($sformatf("row%0d sound", i), bus.sound, vecs[i].exp_sound);
        end

        // Cadence: tone rises 5 cycles into ringing, sound follows one cycle later.
        set_alarm(16'h0730);
        bus.alarm_en = 1'b1;
        arrive("cadence");
        for (int k = 1; k <= 30; k++) begin
            step();
            check($sformatf("cadence sound k=%0d", k), bus.sound, 1'(((k - 1) / 5) % 2));
        end
        $display("cadence: first tone second done, ringing=%b", bus.ringing);
        pulse_tick();
        check("silent second ringing", bus.ringing, 1'b1);
        check("silent second sound", bus.sound, 1'b0);
        for (int k = 0; k < 20; k++) begin
            step();
            check($sformatf("silent k=%0d", k), bus.sound, 1'b0);
        end
        pulse_tick();
        saw_high = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (bus.sound) saw_high = 1'b1;
        end
        check("third second tone present", saw_high, 1'b1);
        check("third second ringing", bus.ringing, 1'b1);
        pulse_tick();
        $display("cadence: third tick, ringing=%b sound=%b", bus.ringing, bus.sound);
        check("auto stop ringing", bus.ringing, 1'b0);
        check("auto stop sound", bus.sound, 1'b0);

        // Snooze return gives a fresh tone and a full 3 s ring.
        arrive("snooze");
        bus.snooze = 1'b1;
        step();
        bus.snooze = 1'b0;
        check("snooze snoozed", bus.snoozed, 1'b1);
        check("snooze sound", bus.sound, 1'b0);
        pulse_tick();
        check("snooze 1 tick snoozed", bus.snoozed, 1'b1);
        pulse_tick();
        check("snooze return ringing", bus.ringing, 1'b1);
        check("snooze return snoozed", bus.snoozed, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("resume sound k=%0d", k), bus.sound, 1'(((k - 1) / 5) % 2));
        end
        pulse_tick();
        check("resume tick1 ringing", bus.ringing, 1'b1);
        pulse_tick();
        check("resume tick2 ringing", bus.ringing, 1'b1);
        pulse_tick();
        $display("snooze: resumed ring ended, ringing=%b", bus.ringing);
        check("resume tick3 ringing", bus.ringing, 1'b0);

        // Reset mid-ring with time held at the alarm value.
        arrive("reset");
        repeat (8) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midring rst ringing", bus.ringing, 1'b0);
        check("midring rst snoozed", bus.snoozed, 1'b0);
        check("midring rst sound", bus.sound, 1'b0);
        saw_high = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (bus.ringing) saw_high = 1'b1;
        end
        $display("reset: held at alarm after reset, rang=%b", saw_high);
        check("no ring after reset", saw_high, 1'b0);
        arrive("post reset");
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        check("post reset stop", bus.ringing, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alarm_ringer.md
Name: alarm_ringer

Overview:
- Sits directly downstream of the watch time counter.
- Compares the current BCD time (hour-tens, hour-ones, minute-tens, minute-ones) with a programmed alarm time.
- On a match, runs a ring/snooze/stop state machine and drives a gated square-wave tone to the board's audio pin.
- Also provides status flags for LEDs.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz.
- TONE_HZ, 1000, audible tone frequency in Hz. HALF = CLK_HZ/(2*TONE_HZ), integer division, must be ≥1.
- RING_SEC, 60, seconds of ringing before automatic stop.
- SNOOZE_SEC, 300, seconds of silence after a snooze before ringing resumes.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- sec_tick  in  1  one-cycle pulse per second from the watch.
- hourdec_now  in  4  current hour tens, BCD.
- hourone_now  in  4  current hour ones, BCD.
- mindec_now  in  4  current minute tens, BCD.
- minone_now  in  4  current minute ones, BCD.
- hourdec_alarm  in  4  alarm hour tens.
- hourone_alarm  in  4  alarm hour ones.
- mindec_alarm  in  4  alarm minute tens.
- minone_alarm  in  4  alarm minute ones.
- alarm_en  in  1  alarm armed (level).
- stop  in  1  one-cycle pulse, already debounced: silence and disarm until the next match.
- snooze  in  1  one-cycle pulse, already debounced: silence for SNOOZE_SEC.
- sound  out  1  gated square wave to the speaker.
- ringing  out  1  high in RINGING.
- snoozed  out  1  high in SNOOZE.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high; all state updates on the rising clk edge.
- Reset values:
  - state = IDLE; sound = 0, ringing = 0, snoozed = 0.
  - All counters = 0; tone = 0; beep_phase = 0.
  - match_d = 1. This prevents a spurious trigger in the first cycle after reset.
- Match logic:
  - match is high when all four now-digits equal the alarm digits. Raw 4-bit compare; no BCD validation.
  - match_d is match registered every cycle.
  - trigger = match & ~match_d & alarm_en, i.e. a rising edge of match only.
  - A time held at the alarm value triggers at most once per arrival.
- States: IDLE, RINGING, SNOOZE.
- Transitions (evaluated each cycle, priority top to bottom):
  1. alarm_en = 0 → IDLE from any state.
  2. stop → IDLE from RINGING or SNOOZE.
  3. snooze in RINGING → SNOOZE; snooze_cnt loaded with SNOOZE_SEC. Snooze in IDLE or SNOOZE is ignored.
  4. IDLE & trigger → RINGING; ring_cnt loaded with RING_SEC.
  5. RINGING & sec_tick:
     - If ring_cnt == 1 → IDLE.
     - Else ring_cnt decrements.
  6. SNOOZE & sec_tick:
     - If snooze_cnt == 1 → RINGING; ring_cnt reloaded with RING_SEC.
     - Else snooze_cnt decrements.
- Triggers outside IDLE: ignored in RINGING and SNOOZE.
- Output timing:
  - ringing and snoozed are registered state decodes. They are valid the cycle after the transition edge.
  - Latency from trigger to ringing = 1 cycle.
- Tone generator:
  - The divider counts 0..HALF-1 and toggles tone on the wrap.
  - Divider and tone are cleared on every entry to RINGING. The first tone rise therefore comes HALF cycles after ringing rises.
  - Divider is held at 0 outside RINGING.
- Beep cadence:
  - beep_phase is set to 1 on entry to RINGING and toggles on each sec_tick while RINGING.
  - Result: 1 s of tone, 1 s of silence, alternating.
- sound output:
  - sound = tone & beep_phase & (state == RINGING), registered.
  - sound is 0 in IDLE and SNOOZE.
- Simultaneous events:
  - stop and snooze in the same cycle → stop wins.
  - snooze and a final-second sec_tick in the same cycle → SNOOZE wins.
  - sec_tick in the same cycle as entering RINGING does not decrement the freshly loaded ring_cnt.
- Reset mid-ring: next cycle sound = 0, ringing = 0, snoozed = 0, state = IDLE. With match_d = 1, no re-trigger until the time leaves and re-enters the alarm value.

Decomposition:
- alarm_pkg holds:
  - state_t enum {IDLE, RINGING, SNOOZE}.
  - bcd_time_t packed struct {hourdec, hourone, mindec, minone}, 4 bits each.
  - Function bcd_time_eq.
- Sub-module tone_gen (parameters CLK_HZ, TONE_HZ; ports clk, rst, en, tone):
  - Owns the divider.
  - Clears when en = 0.

Test Plan (CLK_HZ=1000, TONE_HZ=100 → HALF=5, RING_SEC=3, SNOOZE_SEC=2, sec_tick every 1000 cycles):
1. Basic ring: alarm 07:30, alarm_en=1, time steps 07:29→07:30 → ringing=1 one cycle later; sound toggles every 5 cycles during ticks 0-1, silent during ticks 1-2; ringing=0 after the 3rd sec_tick.
2. Stop: stop pulse mid-ring → next cycle ringing=0, sound=0. Time held at 07:30 for 5 s → no re-trigger. Time 07:31→07:30 → rings again.
3. Snooze: snooze pulse while ringing → snoozed=1, sound=0. After 2 sec_ticks → ringing=1, snoozed=0, full 3 s ring follows.
4. Disarm and priority: alarm_en=0 during SNOOZE → IDLE next cycle. stop+snooze in the same cycle while ringing → IDLE, snoozed stays 0.
5. Reset: rst asserted while ringing with time = alarm → all outputs 0 next cycle, no ring after rst releases while time stays 07:30.
6. Mismatch: alarm 23:59, time 13:59 → no ring. alarm_en=0 at 23:59 arrival → no ring, and setting alarm_en=1 later in the same minute does not ring.
